// File: rtl/axi_slice128_pkg.sv
// axi_slice128_pkg: payload widths of the five channels of the 128-bit AXI register slice.
package axi_slice128_pkg;
    localparam int AXI128_AR_W = 68;
    localparam int AXI128_AW_W = 68;
    localparam int AXI128_W_W  = 153;
    localparam int AXI128_R_W  = 139;
    localparam int AXI128_B_W  = 10;
endpackage

// File: rtl/axi_slice128_skid_buf.sv
// axi_skid_buf: two-entry skid buffer with registered valid, ready and data on both sides.
module axi_skid_buf #(
    parameter int DW = 1
) (
    input  logic          pll_core_cpuclk,
    input  logic          pad_cpu_rst_b,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data
);
    logic          r_m_vld;
    logic          r_s_vld;
    logic [DW-1:0] r_m_dat;
    logic [DW-1:0] r_s_dat;
    logic          w_push;
    logic          w_pop;

    assign w_push      = i_in_valid & ~r_s_vld;
    assign w_pop       = r_m_vld & i_out_ready;
    assign o_in_ready  = ~r_s_vld;
    assign o_out_valid = r_m_vld;
    assign o_out_data  = r_m_dat;

    // A full skid blocks pushes, so the skid-full branch only has to handle the refill of main.
    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_m_vld <= 1'b0;
            r_s_vld <= 1'b0;
            r_m_dat <= '0;
            r_s_dat <= '0;
        end else if (r_s_vld) begin
            if (w_pop) begin
                r_m_dat <= r_s_dat;
                r_s_vld <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_m_vld || w_pop) begin
                r_m_vld <= 1'b1;
                r_m_dat <= i_in_data;
            end else begin
                r_s_vld <= 1'b1;
                r_s_dat <= i_in_data;
            end
        end else if (w_pop) begin
            r_m_vld <= 1'b0;
        end
    end
endmodule

// File: rtl/axi_slice128.sv
// axi_slice128: full-throughput register slice between the CPU AXI master and the 128-bit memory slave.
// Every channel passes through its own skid buffer; the top only packs and unpacks payloads.
module axi_slice128
    import axi_slice128_pkg::*;
(
    input  logic         pll_core_cpuclk,
    input  logic         pad_cpu_rst_b,
    input  logic [39:0]  araddr_m,
    input  logic [1:0]   arburst_m,
    input  logic [3:0]   arcache_m,
    input  logic [7:0]   arid_m,
    input  logic [7:0]   arlen_m,
    input  logic [2:0]   arprot_m,
    input  logic [2:0]   arsize_m,
    input  logic         arvalid_m,
    output logic         arready_m,
    output logic [39:0]  araddr_s0,
    output logic [1:0]   arburst_s0,
    output logic [3:0]   arcache_s0,
    output logic [7:0]   arid_s0,
    output logic [7:0]   arlen_s0,
    output logic [2:0]   arprot_s0,
    output logic [2:0]   arsize_s0,
    output logic         arvalid_s0,
    input  logic         arready_s0,
    input  logic [39:0]  awaddr_m,
    input  logic [1:0]   awburst_m,
    input  logic [3:0]   awcache_m,
    input  logic [7:0]   awid_m,
    input  logic [7:0]   awlen_m,
    input  logic [2:0]   awprot_m,
    input  logic [2:0]   awsize_m,
    input  logic         awvalid_m,
    output logic         awready_m,
    output logic [39:0]  awaddr_s0,
    output logic [1:0]   awburst_s0,
    output logic [3:0]   awcache_s0,
    output logic [7:0]   awid_s0,
    output logic [7:0]   awlen_s0,
    output logic [2:0]   awprot_s0,
    output logic [2:0]   awsize_s0,
    output logic         awvalid_s0,
    input  logic         awready_s0,
    input  logic [127:0] wdata_m,
    input  logic [15:0]  wstrb_m,
    input  logic [7:0]   wid_m,
    input  logic         wlast_m,
    input  logic         wvalid_m,
    output logic         wready_m,
    output logic [127:0] wdata_s0,
    output logic [15:0]  wstrb_s0,
    output logic [7:0]   wid_s0,
    output logic         wlast_s0,
    output logic         wvalid_s0,
    input  logic         wready_s0,
    input  logic [127:0] rdata_s0,
    input  logic [7:0]   rid_s0,
    input  logic [1:0]   rresp_s0,
    input  logic         rlast_s0,
    input  logic         rvalid_s0,
    output logic         rready_s0,
    output logic [127:0] rdata_m,
    output logic [7:0]   rid_m,
    output logic [1:0]   rresp_m,
    output logic         rlast_m,
    output logic         rvalid_m,
    input  logic         rready_m,
    input  logic [7:0]   bid_s0,
    input  logic [1:0]   bresp_s0,
    input  logic         bvalid_s0,
    output logic         bready_s0,
    output logic [7:0]   bid_m,
    output logic [1:0]   bresp_m,
    output logic         bvalid_m,
    input  logic         bready_m
);
    logic [AXI128_AR_W-1:0] w_ar_out;
    logic [AXI128_AW_W-1:0] w_aw_out;
    logic [AXI128_W_W-1:0]  w_w_out;
    logic [AXI128_R_W-1:0]  w_r_out;
    logic [AXI128_B_W-1:0]  w_b_out;

    assign {araddr_s0, arburst_s0, arcache_s0, arid_s0, arlen_s0, arprot_s0, arsize_s0} = w_ar_out;
    assign {awaddr_s0, awburst_s0, awcache_s0, awid_s0, awlen_s0, awprot_s0, awsize_s0} = w_aw_out;
    assign {wdata_s0, wstrb_s0, wid_s0, wlast_s0} = w_w_out;
    assign {rdata_m, rid_m, rresp_m, rlast_m} = w_r_out;
    assign {bid_m, bresp_m} = w_b_out;

    axi_skid_buf #(.DW(AXI128_AR_W)) u_ar (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_in_valid      (arvalid_m),
        .o_in_ready      (arready_m),
        .i_in_data       ({araddr_m, arburst_m, arcache_m, arid_m, arlen_m, arprot_m, arsize_m}),
        .o_out_valid     (arvalid_s0),
        .i_out_ready     (arready_s0),
        .o_out_data      (w_ar_out)
    );

    axi_skid_buf #(.DW(AXI128_AW_W)) u_aw (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_in_valid      (awvalid_m),
        .o_in_ready      (awready_m),
        .i_in_data       ({awaddr_m, awburst_m, awcache_m, awid_m, awlen_m, awprot_m, awsize_m}),
        .o_out_valid     (awvalid_s0),
        .i_out_ready     (awready_s0),
        .o_out_data      (w_aw_out)
    );

    axi_skid_buf #(.DW(AXI128_W_W)) u_w (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_in_valid      (wvalid_m),
        .o_in_ready      (wready_m),
        .i_in_data       ({wdata_m, wstrb_m, wid_m, wlast_m}),
        .o_out_valid     (wvalid_s0),
        .i_out_ready     (wready_s0),
        .o_out_data      (w_w_out)
    );

    // Response channels flow slave to master, so their source side is the _s0 port.
    axi_skid_buf #(.DW(AXI128_R_W)) u_r (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_in_valid      (rvalid_s0),
        .o_in_ready      (rready_s0),
        .i_in_data       ({rdata_s0, rid_s0, rresp_s0, rlast_s0}),
        .o_out_valid     (rvalid_m),
        .i_out_ready     (rready_m),
        .o_out_data      (w_r_out)
    );

    axi_skid_buf #(.DW(AXI128_B_W)) u_b (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .i_in_valid      (bvalid_s0),
        .o_in_ready      (bready_s0),
        .i_in_data       ({bid_s0, bresp_s0}),
        .o_out_valid     (bvalid_m),
        .i_out_ready     (bready_m),
        .o_out_data      (w_b_out)
    );
endmodule
